// File: rtl/alufunc.sv
// Execute-stage ALU function decoder: maps opcode/funct from the E pipeline
// register onto the MIPS R-type funct code space, registered for one cycle.
module alufunc #(
    parameter logic [5:0] RESET_FUNC   = 6'b000000,
    parameter logic [5:0] DEFAULT_FUNC = 6'b100001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] E_op,
    input  logic [5:0] E_func,
    output logic [5:0] e_alufunc
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    // Not a real funct: the ALU treats it as "shift B left 16" for lui.
    localparam logic [5:0] FN_LUI   = 6'b001111;

    logic [5:0] func_next;

    always_comb begin
        func_next = DEFAULT_FUNC;
        case (E_op)
            OP_RTYPE: func_next = E_func;
            OP_ADDI:  func_next = FN_ADD;
            OP_ADDIU: func_next = FN_ADDU;
            OP_SLTI:  func_next = FN_SLT;
            OP_SLTIU: func_next = FN_SLTU;
            OP_ANDI:  func_next = FN_AND;
            OP_ORI:   func_next = FN_OR;
            OP_XORI:  func_next = FN_XOR;
            OP_LUI:   func_next = FN_LUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW,
            OP_J, OP_JAL:
                      func_next = FN_ADDU;
            OP_BEQ, OP_BNE:
                      func_next = FN_SUBU;
            default:  func_next = DEFAULT_FUNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e_alufunc <= RESET_FUNC;
        else
            e_alufunc <= func_next;
    end

endmodule

// File: tb/tb_alufunc.sv
// Directed + random bench for alufunc; expected codes are queued when the
// inputs are driven and popped one edge later when the register shows them.
module tb_alufunc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] E_op;
    logic [5:0] E_func;
    logic [5:0] e_alufunc;

    int checks = 0;
    int passed = 0;
    logic [5:0] exp_q[$];
    logic [5:0] ref_tab[64];

    alufunc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E_op      (E_op),
        .E_func    (E_func),
        .e_alufunc (e_alufunc)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000)
            return fn;
        return ref_tab[op];
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Drive between edges, queue the expectation, then compare #1 after the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] exp;
        @(negedge clk);
        E_op   = op;
        E_func = fn;
        exp_q.push_back(ref_decode(op, fn));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, e_alufunc);
        end else begin
            exp = exp_q.pop_front();
            check(tag, e_alufunc, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_tab[i] = 6'b100001;
        ref_tab[6'b001000] = 6'b100000;
        ref_tab[6'b001001] = 6'b100001;
        ref_tab[6'b001010] = 6'b101010;
        ref_tab[6'b001011] = 6'b101011;
        ref_tab[6'b001100] = 6'b100100;
        ref_tab[6'b001101] = 6'b100101;
        ref_tab[6'b001110] = 6'b100110;
        ref_tab[6'b001111] = 6'b001111;
        ref_tab[6'b000100] = 6'b100011;
        ref_tab[6'b000101] = 6'b100011;

        // Reset held: inputs toggle, output must stay at the reset code.
        rst_n  = 1'b0;
        E_op   = 6'b001000;
        E_func = 6'b111111;
        #1;
        check("reset_initial", e_alufunc, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            E_op   = 6'(i + 8);
            E_func = 6'(i * 7);
            @(posedge clk);
            #1;
            check("reset_held", e_alufunc, 6'b000000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        step("reset_release_add", 6'b000000, 6'b100000);

        step("rtype_sub", 6'b000000, 6'b100010);
        step("rtype_and", 6'b000000, 6'b100100);
        step("rtype_or",  6'b000000, 6'b100101);
        step("rtype_slt", 6'b000000, 6'b101010);
        step("rtype_sll", 6'b000000, 6'b000000);
        step("rtype_odd", 6'b000000, 6'b010111);

        step("addi",  6'b001000, 6'b111111);
        step("addiu", 6'b001001, 6'b111111);
        step("slti",  6'b001010, 6'b111111);
        step("sltiu", 6'b001011, 6'b111111);
        step("andi",  6'b001100, 6'b111111);
        step("ori",   6'b001101, 6'b111111);
        step("xori",  6'b001110, 6'b111111);
        step("lui",   6'b001111, 6'b111111);

        step("lw",     6'b100011, 6'b000000);
        step("lb",     6'b100000, 6'b101010);
        step("lhu",    6'b100101, 6'b101010);
        step("sw",     6'b101011, 6'b000000);
        step("sh",     6'b101001, 6'b100010);
        step("beq",    6'b000100, 6'b000000);
        step("bne",    6'b000101, 6'b100101);
        step("j",      6'b000010, 6'b000000);
        step("jal",    6'b000011, 6'b101010);
        step("unused", 6'b111111, 6'b101010);
        step("unused2", 6'b010000, 6'b000000);

        // Asynchronous reset between edges with a stable 100010 on the output.
        step("pre_async_sub", 6'b000000, 6'b100010);
        @(negedge clk);
        check("async_stable", e_alufunc, 6'b100010);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_drop", e_alufunc, 6'b000000);
        @(posedge clk);
        #1;
        check("async_held_edge", e_alufunc, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        step("async_resume", 6'b001101, 6'b000000);

        for (int i = 0; i < 20; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = (i % 4 == 0) ? 6'b000000 : 6'($urandom_range(0, 63));
            fn = 6'($urandom_range(0, 63));
            step("random", op, fn);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
